pipeline_ctrl: RTL and testbench

Central hazard and stall sequencer for the five-stage CPU pipeline. It owns the control inputs of the IF/ID register and the other pipeline registers: PC write enable, IF/ID stall and flush, ID/EX bubble insertion, and the global `cpu_stall` freeze driven by data-cache misses. Branch flushes that arrive during a cache freeze are held by a small state machine and released once the freeze ends. An optional performance-counter bank can be compiled in.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: controller FSM states, register-index width
// and the hazard priority encoding used by pipeline_ctrl.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } pipe_ctrl_state_e;

   // Hazard priority, highest first: a cache freeze overrides a load-use stall,
   // which overrides a flush, which overrides normal issue.
   localparam int PRIO_CPU_STALL = 0;
   localparam int PRIO_LOAD_USE  = 1;
   localparam int PRIO_FLUSH     = 2;
   localparam int PRIO_NORMAL    = 3;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a hazard).
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
   input  logic                  ex_memread_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   output logic                  lu_o
);

   assign lu_o = ex_memread_i & (ex_rd_i != '0) &
                 ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: cache-miss freeze,
// load-use bubble, branch flush (held across a freeze) and miss watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall/flush/bubble performance counters.
module pipeline_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W   = cpu_pkg::REG_ADDR_W,
   parameter int CNT_W        = 32,
   parameter int MISS_TIMEOUT = 1023
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  ex_memread_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_req_i,
   input  logic                  mem_ack_i,
   output logic                  pc_write_o,
   output logic                  if_id_stall_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  cpu_stall_o,
   output logic                  error_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o,
   output logic [CNT_W-1:0]      bubble_cnt_o
);

   localparam int                WCNT_W   = (MISS_TIMEOUT > 0) ? $clog2(MISS_TIMEOUT + 1) : 1;
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MISS_TIMEOUT);

   pipe_ctrl_state_e  st_q, st_d;
   logic              flush_pend_q, flush_pend_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              error_q, error_d;

   logic lu;
   logic cpu_stall, pc_write, if_id_stall, if_id_flush, id_ex_bubble;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .ex_memread_i (ex_memread_i),
      .ex_rd_i      (ex_rd_i),
      .id_rs1_i     (id_rs1_i),
      .id_rs2_i     (id_rs2_i),
      .lu_o         (lu)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         st_q         <= RUN;
         flush_pend_q <= 1'b0;
         wait_cnt_q   <= '0;
         error_q      <= 1'b0;
      end else begin
         st_q         <= st_d;
         flush_pend_q <= flush_pend_d;
         wait_cnt_q   <= wait_cnt_d;
         error_q      <= error_d;
      end
   end

   always_comb begin
      st_d         = st_q;
      flush_pend_d = flush_pend_q;
      wait_cnt_d   = wait_cnt_q;
      error_d      = error_q;
      cpu_stall    = 1'b0;
      pc_write     = 1'b1;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;

      if (st_q == RUN) begin
         wait_cnt_d = '0;
         if (mem_req_i && !mem_ack_i) begin
            st_d      = WAIT;
            cpu_stall = 1'b1;
         end
      end else begin
         if (mem_ack_i) st_d = RUN;
         else           cpu_stall = 1'b1;
         if (wait_cnt_q != WCNT_MAX) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
         if ((MISS_TIMEOUT != 0) && (wait_cnt_q == WCNT_MAX)) error_d = 1'b1;
      end

      // A branch that collides with a load-use hazard is dropped; ID re-resolves it.
      if (cpu_stall) begin
         pc_write = 1'b0;
         if (branch_taken_i && !lu) flush_pend_d = 1'b1;
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_stall  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if ((branch_taken_i && !lu) || flush_pend_q) begin
         if_id_flush  = 1'b1;
         flush_pend_d = 1'b0;
      end
   end

   assign cpu_stall_o    = rst_i & cpu_stall;
   assign pc_write_o     = rst_i & pc_write;
   assign if_id_stall_o  = rst_i & if_id_stall;
   assign if_id_flush_o  = rst_i & if_id_flush;
   assign id_ex_bubble_o = rst_i & id_ex_bubble;
   assign error_o        = error_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
      if (en && (cnt != '1)) return cnt + CNT_W'(1);
      return cnt;
   endfunction

   always_comb begin
      stall_cnt_d  = sat_inc(stall_cnt_q, cpu_stall_o);
      flush_cnt_d  = sat_inc(flush_cnt_q, if_id_flush_o);
      bubble_cnt_d = sat_inc(bubble_cnt_q, id_ex_bubble_o);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign flush_cnt_o  = flush_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign stall_cnt_o  = '0;
   assign flush_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl; control outputs are checked as the
// packed vector {pc_write, if_id_stall, if_id_flush, id_ex_bubble, cpu_stall}.
module tb_pipeline_ctrl;

   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 32;

   logic                  clk = 1'b0;
   logic                  rst_i;
   logic [REG_ADDR_W-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic                  ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
   logic                  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o;
   logic                  cpu_stall_o, error_o;
   logic [CNT_W-1:0]      stall_cnt_o, flush_cnt_o, bubble_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .REG_ADDR_W   (REG_ADDR_W),
      .CNT_W        (CNT_W),
      .MISS_TIMEOUT (8)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .id_rs1_i       (id_rs1_i),
      .id_rs2_i       (id_rs2_i),
      .ex_memread_i   (ex_memread_i),
      .ex_rd_i        (ex_rd_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .if_id_stall_o  (if_id_stall_o),
      .if_id_flush_o  (if_id_flush_o),
      .id_ex_bubble_o (id_ex_bubble_o),
      .cpu_stall_o    (cpu_stall_o),
      .error_o        (error_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o),
      .bubble_cnt_o   (bubble_cnt_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic br, input logic req, input logic ack);
      ex_memread_i   = memread;
      ex_rd_i        = rd;
      id_rs1_i       = rs1;
      id_rs2_i       = rs2;
      branch_taken_i = br;
      mem_req_i      = req;
      mem_ack_i      = ack;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic [4:0] exp);
      check_eq(tag, {27'd0, pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, cpu_stall_o},
               {27'd0, exp});
   endtask

   initial begin
      rst_i = 1'b0;
      idle();
      tick();

      // reset: outputs forced low even with a miss request present
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      check_ctrl("reset_ctrl", 5'b00000);
      check_eq("reset_error", {31'd0, error_o}, 32'd0);
      check_eq("reset_stall_cnt", stall_cnt_o, 32'd0);
      idle();
      tick();
      rst_i = 1'b1;
      #1;
      check_ctrl("normal", 5'b10000);

      // load-use via rs2, one cycle only
      drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
      check_ctrl("lu_rs2", 5'b01010);
      tick(); idle();
      check_ctrl("lu_after", 5'b10000);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_ctrl("lu_x0", 5'b10000);
      drive(1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, 1'b0);
      check_ctrl("lu_rs1", 5'b01010);
      drive(1'b0, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, 1'b0);
      check_ctrl("no_load", 5'b10000);
      tick();

      // cache hit
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check_ctrl("hit", 5'b10000);
      tick(); idle();
      check_ctrl("hit_stays_run", 5'b10000);

      // plain branch flush
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      check_ctrl("branch", 5'b10100);
      tick(); idle();
      check_ctrl("branch_after", 5'b10000);

      // 4-cycle miss with branch in stall cycle 2
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_ctrl("miss_c1", 5'b00001);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      check_ctrl("miss_c2_br", 5'b00001);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_ctrl("miss_c3", 5'b00001);
      tick();
      check_ctrl("miss_c4", 5'b00001);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check_ctrl("miss_ack_flush", 5'b10100);
      tick(); idle();
      check_ctrl("miss_after", 5'b10000);

      // load-use and branch together: branch dropped, nothing pending
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
      check_ctrl("conflict", 5'b01010);
      tick(); idle();
      check_ctrl("conflict_no_pend", 5'b10000);

      // load-use during a freeze, then in the ack cycle
      drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0);
      check_ctrl("lu_under_stall", 5'b00001);
      tick();
      drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1);
      check_ctrl("lu_ack_cycle", 5'b01010);
      tick(); idle();
      check_ctrl("lu_ack_after", 5'b10000);

      // watchdog: unacked miss, timeout 8
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("wd_pre_%0d", i), {31'd0, error_o}, 32'd0);
         tick();
      end
      check_eq("wd_set", {31'd0, error_o}, 32'd1);
      tick();
      check_eq("wd_sticky", {31'd0, error_o}, 32'd1);
      check_ctrl("wd_still_wait", 5'b00001);

      // reset mid-WAIT
      rst_i = 1'b0;
      idle();
      check_ctrl("rst_wait_ctrl", 5'b00000);
      tick();
      rst_i = 1'b1;
      #1;
      check_eq("rst_wait_error", {31'd0, error_o}, 32'd0);
      check_ctrl("rst_wait_run", 5'b10000);
      check_eq("cnt_clr_stall", stall_cnt_o, 32'd0);
      check_eq("cnt_clr_flush", flush_cnt_o, 32'd0);
      check_eq("cnt_clr_bubble", bubble_cnt_o, 32'd0);

      // perf workload: 3-cycle miss, 2 flushes, 1 bubble
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick(); tick(); tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check_ctrl("perf_ack", 5'b10000);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      tick(); idle(); tick();
`ifdef PIPE_CTRL_PERF_EN
      check_eq("perf_stall", stall_cnt_o, 32'd3);
      check_eq("perf_flush", flush_cnt_o, 32'd2);
      check_eq("perf_bubble", bubble_cnt_o, 32'd1);
`else
      check_eq("perf_stall", stall_cnt_o, 32'd0);
      check_eq("perf_flush", flush_cnt_o, 32'd0);
      check_eq("perf_bubble", bubble_cnt_o, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
